score_renderer: RTL and testbench
=================================

SCORE_RENDERER -- requirements
Module: score_renderer

Interface
REQ-001 SHALL have parameter PIXEL_DISPLAY_BIT, default 9, meaning MSB index of the X/Y pixel coordinates.
REQ-002 SHALL have parameter NUM_DIGITS, default 3, range 1..4, meaning number of displayed decimal digits.
REQ-003 SHALL have parameter SCORE_W, default 10, meaning width of the score input.
REQ-004 SHALL have parameters ORIGIN_X, default 445, and ORIGIN_Y, default 466, meaning top-left pixel of digit 0 (most significant).
REQ-005 SHALL have parameters DIGIT_W, default 10, DIGIT_H, default 10, and DIGIT_GAP, default 5, meaning glyph cell size and horizontal spacing in pixels.
REQ-006 SHALL have parameter SATURATE, default 1, meaning 1 = hold at all-nines and 0 = wrap to zero on overflow.
REQ-007 SHALL have parameter BLANK_LZ, default 1, meaning suppress leading zeros.
REQ-008 SHALL have port clock_25, input, 1 bit, meaning the single pixel clock; all logic is on its rising edge.
REQ-009 SHALL have port sync_reset, input, 1 bit, meaning synchronous active-high reset.
REQ-010 SHALL have port score, input, SCORE_W bits, meaning binary game score.
REQ-011 SHALL have port show_hi, input, 1 bit, meaning 1 = render the high score and 0 = render the current score.
REQ-012 SHALL have ports X and Y, input, PIXEL_DISPLAY_BIT+1 bits each, meaning the current scan pixel.
REQ-013 SHALL have port number_pixel, input, 1 bit, meaning the glyph ROM bit for (selected_score_number, glyph_addr), combinational from those outputs.
REQ-014 SHALL have port selected_score_number, output, 4 bits, meaning BCD digit being drawn.
REQ-015 SHALL have port glyph_addr, output, clog2(DIGIT_W*DIGIT_H) bits, meaning row-major offset inside the glyph.
REQ-016 SHALL have port score_enable, output, 1 bit, meaning draw a foreground pixel.
REQ-017 SHALL have port overflow, output, 1 bit, meaning sticky flag set on the first BCD overflow.

Function
REQ-018 Digit i cell SHALL be X in [ORIGIN_X+i*(DIGIT_W+DIGIT_GAP), +DIGIT_W-1] and Y in [ORIGIN_Y, ORIGIN_Y+DIGIT_H-1], both bounds inclusive.
REQ-019 Stage 1 SHALL register in_cell, the digit index, selected_score_number and glyph_addr = (Y-ORIGIN_Y)*DIGIT_W + (X-cell_x0) one cycle after X/Y; outside every cell, selected_score_number and glyph_addr SHALL be 0.
REQ-020 Stage 2 SHALL register score_enable = number_pixel AND in_cell(stage1) AND NOT blank(stage1), giving total latency of 2 cycles from X/Y.
REQ-021 With BLANK_LZ=1, digit i SHALL be blanked when it and all more-significant digits are 0, and the last digit SHALL never be blanked.
REQ-022 Catch-up: each cycle with score > score_prev SHALL increment the current BCD by exactly one and score_prev by one, so a jump of k completes in k cycles.
REQ-023 When score < score_prev (new round), the current BCD and score_prev SHALL clear to 0 in one cycle, with catch-up resuming on the next cycle.
REQ-024 Increment SHALL ripple: a digit at 9 becomes 0 and carries to the next-more-significant digit.
REQ-025 Overflow from all-nines SHALL hold the value when SATURATE=1 and SHALL give all zeros when SATURATE=0, and SHALL set overflow in both cases.
REQ-026 The high-score BCD SHALL load the current BCD on the cycle after the current value exceeds it; it is not cleared by a round restart.
REQ-027 The displayed value SHALL be sampled once per frame, at X=0,Y=0, to prevent tearing; show_hi SHALL be sampled at the same instant.

Reset
REQ-028 sync_reset=1 SHALL clear current BCD, high BCD, score_prev, overflow, displayed-value latch and both pipeline stages, leaving all outputs 0 on the next edge.
REQ-029 sync_reset SHALL take priority over a simultaneous increment or clear, including reset asserted mid-catch-up.

Structure
REQ-030 A shared package SHALL hold the 4-bit BCD digit type and the default geometry constants.
REQ-031 One sub-module bcd_counter SHALL implement NUM_DIGITS ripple increment, saturate/wrap and the overflow output.

Verification
REQ-032 Reset then score=0→7: after 7 cycles the current BCD SHALL be 007 and overflow SHALL be 0.
REQ-033 Score 0→999→1000, SATURATE=1: the current BCD SHALL hold 999 and overflow SHALL equal 1; with SATURATE=0 it SHALL read 000.
REQ-034 Score 42 then 5: the current BCD SHALL be 000 then reach 005, and the high score SHALL remain 042 with show_hi=1 rendering 042.
REQ-035 Value 007, BLANK_LZ=1, scan X=445..484 at Y=466: score_enable SHALL be 0 over digits 0–1, and digit 2 pixels SHALL appear 2 cycles late with glyph_addr 0..9.
REQ-036 Pixel X=454,Y=475: glyph_addr SHALL be 99; X=455, the gap, SHALL give score_enable 0 and glyph_addr 0.
REQ-037 sync_reset asserted during catch-up 0→50 at count 20: the next edge SHALL give all zeros with no further increment.

Source files
------------

// File: rtl/score_renderer_pkg.sv
// Shared types and default geometry for the score renderer.
//   bcd_t        : one packed BCD digit
//   DEF_*        : default pixel geometry / widths used as parameter defaults
package score_renderer_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned DEF_PIXEL_DISPLAY_BIT = 9;
  localparam int unsigned DEF_NUM_DIGITS        = 3;
  localparam int unsigned DEF_SCORE_W           = 10;
  localparam int unsigned DEF_ORIGIN_X          = 445;
  localparam int unsigned DEF_ORIGIN_Y          = 466;
  localparam int unsigned DEF_DIGIT_W           = 10;
  localparam int unsigned DEF_DIGIT_H           = 10;
  localparam int unsigned DEF_DIGIT_GAP         = 5;

endpackage

// File: rtl/score_renderer_if.sv
// Scan/glyph bus between a video timing source (master) and the score
// renderer (slave).
//   x, y                  : current scan pixel (master -> renderer)
//   number_pixel          : glyph ROM bit for the renderer's digit/address
//   selected_score_number : BCD digit being drawn (renderer -> master)
//   glyph_addr            : row-major offset inside the glyph cell
//   score_enable          : foreground pixel strobe
interface score_renderer_if #(
  parameter int unsigned PIXEL_DISPLAY_BIT = 9,
  parameter int unsigned GLYPH_AW          = 7
);
  logic [PIXEL_DISPLAY_BIT:0] x;
  logic [PIXEL_DISPLAY_BIT:0] y;
  logic                       number_pixel;
  logic [3:0]                 selected_score_number;
  logic [GLYPH_AW-1:0]        glyph_addr;
  logic                       score_enable;

  modport master (
    output x, y, number_pixel,
    input  selected_score_number, glyph_addr, score_enable
  );

  modport slave (
    input  x, y, number_pixel,
    output selected_score_number, glyph_addr, score_enable
  );
endinterface

// File: rtl/score_renderer_bcd_counter.sv
// NUM_DIGITS-wide BCD up-counter with clear, saturate/wrap and sticky overflow.
//   clk_i, rst_i : clock, synchronous active-high reset (highest priority)
//   clr_i        : clear value to zero (beats inc_i)
//   inc_i        : add one with decimal ripple carry
//   value_o      : BCD value, index NUM_DIGITS-1 is the most significant digit
//   overflow_o   : sticky, set when an increment carries out of all-nines
module bcd_counter
  import score_renderer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   inc_i,
  input  logic                   clr_i,
  output bcd_t [NUM_DIGITS-1:0]  value_o,
  output logic                   overflow_o
);

  bcd_t [NUM_DIGITS-1:0] value_q, value_d, inc_val;
  logic                  ovf_q, ovf_d;
  logic                  carry;

  // Ripple increment from the least significant digit; carry survives all-nines.
  always_comb begin
    inc_val = value_q;
    carry   = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (value_q[i] == 4'd9) begin
          inc_val[i] = 4'd0;
        end else begin
          inc_val[i] = value_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end

    value_d = value_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i) begin
      if (carry) begin
        // inc_val is all zeros here, which is exactly the wrap result
        ovf_d   = 1'b1;
        value_d = SATURATE ? value_q : inc_val;
      end else begin
        value_d = inc_val;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o    = value_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/score_renderer.sv
// Renders a NUM_DIGITS decimal score as glyph cells on a scanned display.
//   clock_25, sync_reset  : pixel clock, synchronous active-high reset
//   score, show_hi        : binary score, select high score for display
//   X, Y                  : current scan pixel
//   number_pixel          : glyph ROM bit for (selected_score_number, glyph_addr)
//   selected_score_number : BCD digit under the scan (stage 1)
//   glyph_addr            : offset inside the glyph cell (stage 1)
//   score_enable          : foreground pixel, 2 cycles after X/Y (stage 2)
//   overflow              : sticky BCD overflow
module score_renderer
  import score_renderer_pkg::*;
#(
  parameter int unsigned PIXEL_DISPLAY_BIT = DEF_PIXEL_DISPLAY_BIT,
  parameter int unsigned NUM_DIGITS        = DEF_NUM_DIGITS,
  parameter int unsigned SCORE_W           = DEF_SCORE_W,
  parameter int unsigned ORIGIN_X          = DEF_ORIGIN_X,
  parameter int unsigned ORIGIN_Y          = DEF_ORIGIN_Y,
  parameter int unsigned DIGIT_W           = DEF_DIGIT_W,
  parameter int unsigned DIGIT_H           = DEF_DIGIT_H,
  parameter int unsigned DIGIT_GAP         = DEF_DIGIT_GAP,
  parameter bit          SATURATE          = 1'b1,
  parameter bit          BLANK_LZ          = 1'b1
) (
  input  logic                                  clock_25,
  input  logic                                  sync_reset,
  input  logic [SCORE_W-1:0]                    score,
  input  logic                                  show_hi,
  input  logic [PIXEL_DISPLAY_BIT:0]            X,
  input  logic [PIXEL_DISPLAY_BIT:0]            Y,
  input  logic                                  number_pixel,
  output logic [3:0]                            selected_score_number,
  output logic [$clog2(DIGIT_W*DIGIT_H)-1:0]    glyph_addr,
  output logic                                  score_enable,
  output logic                                  overflow
);

  localparam int unsigned GLYPH_AW = $clog2(DIGIT_W*DIGIT_H);
  localparam int unsigned PITCH    = DIGIT_W + DIGIT_GAP;
  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  bcd_t [NUM_DIGITS-1:0] cur_bcd;
  bcd_t [NUM_DIGITS-1:0] hi_q, hi_d;
  bcd_t [NUM_DIGITS-1:0] disp_q, disp_d;
  logic [SCORE_W-1:0]    score_prev_q, score_prev_d;
  logic                  inc_c, clr_c;

  logic                  in_cell_q, in_cell_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  bcd_t                  sel_q, sel_d;
  logic [GLYPH_AW-1:0]   addr_q, addr_d;
  logic                  en_q, en_d;
  logic                  lead_zero_c, blank_c;

  // Catch-up one step per cycle; a lower score means a new round.
  assign inc_c = (score > score_prev_q);
  assign clr_c = (score < score_prev_q);

  bcd_counter #(
    .NUM_DIGITS (NUM_DIGITS),
    .SATURATE   (SATURATE)
  ) u_bcd_counter (
    .clk_i      (clock_25),
    .rst_i      (sync_reset),
    .inc_i      (inc_c),
    .clr_i      (clr_c),
    .value_o    (cur_bcd),
    .overflow_o (overflow)
  );

  // Score tracking, high score and once-per-frame display latch.
  always_comb begin
    score_prev_d = score_prev_q;
    hi_d         = hi_q;
    disp_d       = disp_q;
    if (clr_c) begin
      score_prev_d = '0;
    end else if (inc_c) begin
      score_prev_d = score_prev_q + SCORE_W'(1);
    end
    // BCD order matches numeric order, so a plain vector compare suffices
    if (cur_bcd > hi_q) begin
      hi_d = cur_bcd;
    end
    if (X == '0 && Y == '0) begin
      disp_d = show_hi ? hi_q : cur_bcd;
    end
  end

  // Stage 1: locate the scan pixel inside a digit cell.
  always_comb begin
    in_cell_d = 1'b0;
    idx_d     = '0;
    sel_d     = '0;
    addr_d    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (32'(X) >= ORIGIN_X + i*PITCH && 32'(X) < ORIGIN_X + i*PITCH + DIGIT_W &&
          32'(Y) >= ORIGIN_Y && 32'(Y) < ORIGIN_Y + DIGIT_H) begin
        in_cell_d = 1'b1;
        idx_d     = IDX_W'(i);
        sel_d     = disp_q[NUM_DIGITS-1-i];
        addr_d    = GLYPH_AW'((32'(Y) - ORIGIN_Y)*DIGIT_W + (32'(X) - ORIGIN_X - i*PITCH));
      end
    end
  end

  // Leading-zero blanking for the stage-1 digit; the last digit always shows.
  always_comb begin
    lead_zero_c = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (j <= 32'(idx_q) && disp_q[NUM_DIGITS-1-j] != 4'd0) begin
        lead_zero_c = 1'b0;
      end
    end
    blank_c = BLANK_LZ && lead_zero_c && (32'(idx_q) != NUM_DIGITS - 1);
    en_d    = number_pixel && in_cell_q && !blank_c;
  end

  always_ff @(posedge clock_25) begin
    if (sync_reset) begin
      score_prev_q <= '0;
      hi_q         <= '0;
      disp_q       <= '0;
      in_cell_q    <= 1'b0;
      idx_q        <= '0;
      sel_q        <= '0;
      addr_q       <= '0;
      en_q         <= 1'b0;
    end else begin
      score_prev_q <= score_prev_d;
      hi_q         <= hi_d;
      disp_q       <= disp_d;
      in_cell_q    <= in_cell_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      en_q         <= en_d;
    end
  end

  assign selected_score_number = sel_q;
  assign glyph_addr            = addr_q;
  assign score_enable          = en_q;

endmodule

// File: tb/tb_score_renderer.sv
// Self-checking bench: two renderers (saturating + blanking, wrapping + no
// blanking) share stimulus; a decimal-arithmetic model predicts every output.
module tb_score_renderer;
  import score_renderer_pkg::*;

  localparam int N     = 3;
  localparam int MAXV  = 999;
  localparam int OX    = 445;
  localparam int OY    = 466;
  localparam int DW    = 10;
  localparam int DH    = 10;
  localparam int PITCH = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       show_hi;
  logic [9:0] score;
  logic       ovf_s, ovf_w;

  score_renderer_if #(.PIXEL_DISPLAY_BIT(9), .GLYPH_AW(7)) if_s ();
  score_renderer_if #(.PIXEL_DISPLAY_BIT(9), .GLYPH_AW(7)) if_w ();

  int n_cyc_checks = 0, n_cyc_fail = 0;
  int n_lit_checks = 0, n_lit_fail = 0;

  // Arbitrary glyph ROM pattern
  function automatic logic rom(input logic [3:0] d, input logic [6:0] a);
    int s;
    s = d;
    s = s + a;
    return (s % 3) != 0;
  endfunction

  assign if_s.number_pixel = rom(if_s.selected_score_number, if_s.glyph_addr);
  assign if_w.number_pixel = rom(if_w.selected_score_number, if_w.glyph_addr);

  always #5 clk = ~clk;

  score_renderer u_s (
    .clock_25(clk), .sync_reset(rst), .score(score), .show_hi(show_hi),
    .X(if_s.x), .Y(if_s.y), .number_pixel(if_s.number_pixel),
    .selected_score_number(if_s.selected_score_number),
    .glyph_addr(if_s.glyph_addr), .score_enable(if_s.score_enable), .overflow(ovf_s));

  score_renderer #(.SATURATE(1'b0), .BLANK_LZ(1'b0)) u_w (
    .clock_25(clk), .sync_reset(rst), .score(score), .show_hi(show_hi),
    .X(if_w.x), .Y(if_w.y), .number_pixel(if_w.number_pixel),
    .selected_score_number(if_w.selected_score_number),
    .glyph_addr(if_w.glyph_addr), .score_enable(if_w.score_enable), .overflow(ovf_w));

  // ---------------- behavioural model ----------------
  int m_prev, m_in1, m_idx1, m_addr1;
  int m_cur[2], m_hi[2], m_ovf[2], m_disp[2], m_sel1[2], m_en2[2];

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int digit_of(input int v, input int i);
    return (v / pow10(N - 1 - i)) % 10;
  endfunction

  // k==0 blanks leading zeros, k==1 never blanks
  function automatic bit blanked(input int k, input int v, input int idx);
    if (k == 1) return 1'b0;
    return (idx < N - 1) && (v < pow10(N - 1 - idx));
  endfunction

  task automatic model_step();
    int x, y, dx, ci, off, c_in, c_idx, c_addr, sc;
    if (rst) begin
      m_prev = 0; m_in1 = 0; m_idx1 = 0; m_addr1 = 0;
      for (int k = 0; k < 2; k++) begin
        m_cur[k] = 0; m_hi[k] = 0; m_ovf[k] = 0; m_disp[k] = 0; m_sel1[k] = 0; m_en2[k] = 0;
      end
      return;
    end
    x = if_s.x; y = if_s.y; sc = score;
    for (int k = 0; k < 2; k++)
      m_en2[k] = (m_in1 != 0) && rom(4'(m_sel1[k]), 7'(m_addr1)) && !blanked(k, m_disp[k], m_idx1);
    c_in = 0; c_idx = 0; c_addr = 0;
    if (x >= OX && y >= OY && y < OY + DH) begin
      dx = x - OX; ci = dx / PITCH; off = dx % PITCH;
      if (ci < N && off < DW) begin
        c_in = 1; c_idx = ci; c_addr = (y - OY) * DW + off;
      end
    end
    for (int k = 0; k < 2; k++) m_sel1[k] = c_in ? digit_of(m_disp[k], c_idx) : 0;
    m_in1 = c_in; m_idx1 = c_idx; m_addr1 = c_addr;
    for (int k = 0; k < 2; k++) begin
      if (x == 0 && y == 0) m_disp[k] = show_hi ? m_hi[k] : m_cur[k];
      if (m_cur[k] > m_hi[k]) m_hi[k] = m_cur[k];
    end
    if (sc < m_prev) begin
      m_prev = 0; m_cur[0] = 0; m_cur[1] = 0;
    end else if (sc > m_prev) begin
      m_prev++;
      for (int k = 0; k < 2; k++) begin
        if (m_cur[k] == MAXV) begin
          m_ovf[k] = 1;
          m_cur[k] = (k == 0) ? MAXV : 0;
        end else begin
          m_cur[k]++;
        end
      end
    end
  endtask

  task automatic check_cyc(input string name, input int act, input int exp);
    n_cyc_checks++;
    if (act != exp) begin
      n_cyc_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_lit_checks++;
    if (act != exp) begin
      n_lit_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(posedge clk) begin
    model_step();
    #1;
    check_cyc("sel_s",  if_s.selected_score_number, m_sel1[0]);
    check_cyc("addr_s", if_s.glyph_addr,            m_in1 ? m_addr1 : 0);
    check_cyc("en_s",   if_s.score_enable,          m_en2[0]);
    check_cyc("ovf_s",  ovf_s,                      m_ovf[0]);
    check_cyc("sel_w",  if_w.selected_score_number, m_sel1[1]);
    check_cyc("addr_w", if_w.glyph_addr,            m_in1 ? m_addr1 : 0);
    check_cyc("en_w",   if_w.score_enable,          m_en2[1]);
    check_cyc("ovf_w",  ovf_w,                      m_ovf[1]);
  end

  // ---------------- stimulus ----------------
  task automatic set_xy(input int x, input int y);
    if_s.x = 10'(x); if_s.y = 10'(y);
    if_w.x = 10'(x); if_w.y = 10'(y);
  endtask

  task automatic step(input int x, input int y);
    @(negedge clk); set_xy(x, y); @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 1);
  endtask

  task automatic set_score(input int v);
    @(negedge clk); score = 10'(v); @(posedge clk); #2;
  endtask

  task automatic read_digits(output int vs, output int vw);
    vs = 0; vw = 0;
    for (int i = 0; i < N; i++) begin
      step(OX + i * PITCH, OY);
      vs = vs * 10 + int'(if_s.selected_score_number);
      vw = vw * 10 + int'(if_w.selected_score_number);
    end
    step(1, 1);
  endtask

  task automatic read_disp(output int vs, output int vw);
    step(0, 0);
    read_digits(vs, vw);
  endtask

  initial begin
    int vs, vw, nxt, r;
    rst = 1'b1; score = '0; show_hi = 1'b0; set_xy(1, 1);
    repeat (2) @(posedge clk);
    #2;
    check_lit("rst_ovf", ovf_s, 0);
    check_lit("rst_sel", if_s.selected_score_number, 0);
    check_lit("rst_en",  if_s.score_enable, 0);
    @(negedge clk); rst = 1'b0; @(posedge clk); #2;

    // 0 -> 7
    set_score(7); idle(8);
    read_disp(vs, vw);
    check_lit("cnt7_s", vs, 7);
    check_lit("cnt7_w", vw, 7);
    check_lit("cnt7_ovf", ovf_s, 0);

    // 42 then new round at 5; high score stays 42
    set_score(42); idle(45);
    set_score(5);
    read_disp(vs, vw);
    check_lit("round_clr", vs, 0);
    idle(6);
    read_disp(vs, vw);
    check_lit("round_5", vs, 5);
    show_hi = 1'b1;
    read_disp(vs, vw);
    check_lit("hi_42_s", vs, 42);
    check_lit("hi_42_w", vw, 42);
    show_hi = 1'b0;

    // Scan row Y=466 with 007 displayed
    set_score(7); idle(4);
    step(0, 0);
    for (int x = OX; x < OX + 40; x++) begin
      step(x, OY);
      if (x >= 446 && x <= 475) check_lit("blank_lz", if_s.score_enable, 0);
      if (x >= 476) check_lit("d2_en", if_s.score_enable, int'(rom(4'd7, 7'(x - 1 - 475))));
      if (x >= 475) check_lit("d2_addr", if_s.glyph_addr, x - 475);
    end
    idle(2);

    // Last pixel of digit 0 and the gap after it
    step(454, 475);
    check_lit("addr99", if_s.glyph_addr, 99);
    step(455, 475);
    check_lit("gap_addr", if_s.glyph_addr, 0);
    check_lit("gap_sel",  if_s.selected_score_number, 0);
    step(1, 1);
    check_lit("gap_en", if_s.score_enable, 0);

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(99, 0);
      if (r < 4) begin
        nxt = $urandom_range(int'(score), 0);
      end else begin
        nxt = int'(score) + $urandom_range(3, 0);
        if (nxt > 1000) nxt = 1000;
      end
      @(negedge clk);
      score = 10'(nxt);
      if (r >= 90) show_hi = ~show_hi;
      if (r % 17 == 0) set_xy(0, 0);
      else set_xy($urandom_range(490, 440), $urandom_range(478, 462));
      @(posedge clk); #2;
    end
    show_hi = 1'b0;

    // Reset during catch-up 0 -> 50 at count 20
    set_score(0); idle(2);
    set_score(50); idle(19);
    @(negedge clk); rst = 1'b1; set_xy(1, 1);
    @(posedge clk); #2;
    check_lit("midrst_sel",  if_s.selected_score_number, 0);
    check_lit("midrst_addr", if_s.glyph_addr, 0);
    check_lit("midrst_en",   if_s.score_enable, 0);
    check_lit("midrst_ovf",  ovf_s, 0);
    @(negedge clk); rst = 1'b0; set_xy(0, 0);
    @(posedge clk); #2;
    read_digits(vs, vw);
    check_lit("midrst_val", vs, 0);
    idle(55);

    // Overflow: 0 -> 999 -> 1000
    set_score(0); idle(2);
    set_score(999); idle(1002);
    read_disp(vs, vw);
    check_lit("top_999", vs, 999);
    check_lit("top_ovf0", ovf_s, 0);
    set_score(1000); idle(3);
    read_disp(vs, vw);
    check_lit("sat_999", vs, 999);
    check_lit("wrap_000", vw, 0);
    check_lit("sat_ovf", ovf_s, 1);
    check_lit("wrap_ovf", ovf_w, 1);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_cyc_checks + n_lit_checks, n_cyc_fail + n_lit_fail);
    $finish;
  end

endmodule
